atmega_pll_lock_mon: RTL and testbench
======================================

// Module: atmega_pll_lock_mon
// PURPOSE
//  Frequency/lock monitor for a PLL-derived clock (tim/usb clock output of the PLL block), running in the CPU clock domain.
//  Prescales the monitored clock in its own domain, counts its edges over a fixed clk window and compares the count to a software target.
//  Drives PLL LOCK status, a sticky lock-lost flag and an interrupt.
//  Sits on the ATmega I/O bus next to PLLCSR/PLLFRQ; the CPU polls LOCK or takes the IRQ before switching timers/USB to the PLL clock.
// PARAMETERS
//  BUS_ADDR_DATA_LEN  16     I/O bus address width
//  MONCSR_ADDR        'h33   control/status register address
//  MONEXP_ADDR        'h34   expected edge count register address
//  MONCNT_ADDR        'h35   measured edge count register address (read-only)
//  WINDOW             256    measurement window length in clk cycles (>=16)
//  PRESCALE_LOG2      4      mon_ck divide factor = 2**PRESCALE_LOG2
//  TOL                2      allowed |measured - expected| for a match
//  LOCK_WINDOWS       3      consecutive matching windows required to declare lock (1..7)
// PORTS
//  rst      in   1                  async reset, active-high (resets both domains)
//  clk      in   1                  CPU/bus clock
//  mon_ck   in   1                  monitored clock, asynchronous to clk
//  addr     in   BUS_ADDR_DATA_LEN  I/O address
//  wr       in   1                  write strobe, sampled at posedge clk
//  rd       in   1                  read strobe
//  bus_in   in   8                  write data
//  bus_out  out  8                  read data, combinational
//  locked   out  1                  1 while FSM is in LOCK
//  irq      out  1                  LOSTF & LOSTIE
// BEHAVIOUR
//  Reset (async, rst=1): MONCSR=0, MONEXP=0, MONCNT=0, FSM=OFF, all counters/synchronizers 0; locked=0, irq=0, bus_out=0.
//  MONCSR bits: [0] EN rw; [1] LOCK ro; [2] LOSTF sticky, write-1-clears; [3] LOSTIE rw; [4] VALID ro (set at first completed window after EN, cleared when EN=0); [7:5] read 0.
//  bus_out: 0 unless rd & ~rst & addr matches one of the three registers; then that register's value.
//  mon_ck domain: PRESCALE_LOG2-bit free-running counter (async reset by rst); its MSB is the divided clock div_ck.
//  clk domain: div_ck passed through a 2-FF synchronizer plus a third FF; a rising edge is (ff2 & ~ff3). Edge detect latency 2-3 clk.
//  Window: while EN=1, win_cnt counts 0..WINDOW-1 and wraps; edge_cnt (8-bit) increments on each detected edge, saturating at 255.
//  At the clk edge where win_cnt==WINDOW-1 (window end): MONCNT<=edge_cnt (including an edge detected that same cycle), edge_cnt<=0, VALID<=1.
//  match = |MONCNT_new - MONEXP| <= TOL, computed in 9-bit signed arithmetic on the value just captured; MONEXP written mid-window is used at the next window end.
//  FSM (evaluated only at window end; match_cnt is 3 bits):
//   OFF : EN=0. On EN 0->1 go ACQ with match_cnt=0, win_cnt=0, edge_cnt=0.
//   ACQ : match -> match_cnt+1; if match_cnt+1==LOCK_WINDOWS go LOCK. No match -> match_cnt=0, stay ACQ.
//   LOCK: match -> stay. No match -> ACQ, match_cnt=0, LOSTF<=1.
//   Any state, EN written 0 -> OFF next clk; win_cnt, edge_cnt, match_cnt, LOCK, VALID cleared; MONCNT and LOSTF retained.
//  locked = LOCK bit; rises on the same clk edge as the LOCK_WINDOWS-th matching capture, falls on the capture that mismatches.
//  Simultaneous LOSTF set (window end) and write-1-clear of LOSTF: set wins.
//  Writes to MONCSR ignore bits 1, 4 and 7:5.
//  MONEXP=0 with mon_ck stopped is a legal match (ACQ->LOCK on a dead clock); software owns the target.
//  rst asserted mid-window or while locked: immediate return to reset values in both domains, no partial capture.
// TESTING
//  1 clk 16MHz, mon_ck 96MHz, MONEXP=96, EN=1 -> MONCNT in 95..97 after each window; locked=1 after exactly 3*256 clk from EN; VALID=1 after 256.
//  2 Locked, then stop mon_ck -> next capture MONCNT<=6, locked falls on that edge, LOSTF=1; with LOSTIE=1 irq=1; write MONCSR=0x05 -> LOSTF=0, irq=0.
//  3 MONEXP=48, mon_ck 96MHz -> never locks, match_cnt stays 0; switch mon_ck to 48MHz -> locked=1 three windows later.
//  4 WINDOW=1024 build, mon_ck 96MHz -> MONCNT=255 (saturated); MONEXP=255 -> locks.
//  5 EN cleared mid-window (clk 100 of 256) -> locked=0, VALID=0 next clk, MONCNT unchanged; re-enable -> full 3-window reacquire.
//  6 LOSTF w1c on same clk as a mismatching capture -> LOSTF reads 1; async rst pulse while locked -> all registers 0, bus_out=0.

Source files
------------

// File: rtl/atmega_pll_lock_mon.sv
// PLL lock monitor: counts prescaled mon_ck edges over a fixed clk window and compares
// the count against a software target to drive LOCK, a sticky lock-lost flag and an IRQ.
module atmega_pll_lock_mon #(
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int MONCSR_ADDR       = 'h33,
  parameter int MONEXP_ADDR       = 'h34,
  parameter int MONCNT_ADDR       = 'h35,
  parameter int WINDOW            = 256,
  parameter int PRESCALE_LOG2     = 4,
  parameter int TOL               = 2,
  parameter int LOCK_WINDOWS      = 3
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic                         mon_ck,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         locked,
  output logic                         irq
);

  localparam int WIN_W = $clog2(WINDOW);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // mon_ck domain: free-running prescaler, MSB is the divided clock
  // ---------------------------------------------------------------------------
  logic [PRESCALE_LOG2-1:0] r_pre_cnt;
  logic                     w_div_ck;

  // NOTE: sequential state is always assigned with <=, so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge mon_ck or posedge rst) begin
    if (rst) r_pre_cnt <= '0;
    else     r_pre_cnt <= r_pre_cnt + 1'b1;
  end

  assign w_div_ck = r_pre_cnt[PRESCALE_LOG2-1];

  // ---------------------------------------------------------------------------
  // clk domain: synchronizer and rising-edge detect of div_ck
  // ---------------------------------------------------------------------------
  logic r_sync1, r_sync2, r_sync3;
  logic w_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= w_div_ck;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_sync3;

  // ---------------------------------------------------------------------------
  // Registers and bus decode
  // ---------------------------------------------------------------------------
  logic             r_en;
  logic             r_lostf;
  logic             r_lostie;
  logic             r_valid;
  logic [7:0]       r_monexp;
  logic [7:0]       r_moncnt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [7:0]       r_edge_cnt;
  logic [2:0]       r_match_cnt;
  state_t           r_state;

  logic w_sel_csr, w_sel_exp, w_sel_cnt;
  logic w_wr_csr, w_wr_exp;
  logic w_en_set, w_en_clr;

  assign w_sel_csr = (addr == BUS_ADDR_DATA_LEN'(MONCSR_ADDR));
  assign w_sel_exp = (addr == BUS_ADDR_DATA_LEN'(MONEXP_ADDR));
  assign w_sel_cnt = (addr == BUS_ADDR_DATA_LEN'(MONCNT_ADDR));
  assign w_wr_csr  = wr & w_sel_csr;
  assign w_wr_exp  = wr & w_sel_exp;
  assign w_en_set  = w_wr_csr &  bus_in[0] & ~r_en;
  assign w_en_clr  = w_wr_csr & ~bus_in[0];

  // ---------------------------------------------------------------------------
  // Window end capture value and match against target
  // ---------------------------------------------------------------------------
  logic              w_win_end;
  logic [7:0]        w_edge_nxt;
  logic signed [8:0] w_diff;
  logic [8:0]        w_abs;
  logic              w_match;

  assign w_win_end  = r_en & (r_win_cnt == WIN_W'(WINDOW - 1));
  assign w_edge_nxt = (w_edge && (r_edge_cnt != 8'hFF)) ? r_edge_cnt + 8'd1 : r_edge_cnt;
  assign w_diff     = $signed({1'b0, w_edge_nxt}) - $signed({1'b0, r_monexp});
  assign w_abs      = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
  assign w_match    = (w_abs <= 9'(TOL));

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t     w_state_nxt;
  logic [2:0] w_match_nxt;
  logic       w_lost;
  logic [2:0] w_match_inc;

  assign w_match_inc = r_match_cnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_lost      = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (w_en_set) begin
          w_state_nxt = ST_ACQ;
          w_match_nxt = '0;
        end
      end
      ST_ACQ: begin
        if (w_win_end) begin
          if (w_match) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == 3'(LOCK_WINDOWS)) w_state_nxt = ST_LOCK;
          end else begin
            w_match_nxt = '0;
          end
        end
      end
      ST_LOCK: begin
        if (w_win_end && !w_match) begin
          w_state_nxt = ST_ACQ;
          w_match_nxt = '0;
          w_lost      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_match_nxt = '0;
      end
    endcase
    // Disabling overrides any window-end activity in the same cycle.
    if (w_en_clr) begin
      w_state_nxt = ST_OFF;
      w_match_nxt = '0;
      w_lost      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Window / edge counters and captured count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_moncnt   <= '0;
      r_valid    <= 1'b0;
    end else if (!r_en || w_en_clr) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_valid    <= 1'b0;
    end else if (w_win_end) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
      r_moncnt   <= w_edge_nxt;
      r_valid    <= 1'b1;
    end else begin
      r_win_cnt  <= r_win_cnt + 1'b1;
      r_edge_cnt <= w_edge_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Software-visible control bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_lostie <= 1'b0;
      r_lostf  <= 1'b0;
      r_monexp <= '0;
    end else begin
      if (w_wr_csr) begin
        r_en     <= bus_in[0];
        r_lostie <= bus_in[3];
      end
      // A hardware set of LOSTF beats a same-cycle write-1-clear.
      if (w_lost)                      r_lostf <= 1'b1;
      else if (w_wr_csr && bus_in[2])  r_lostf <= 1'b0;
      if (w_wr_exp) r_monexp <= bus_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [7:0] w_csr;

  assign locked = (r_state == ST_LOCK);
  assign irq    = r_lostf & r_lostie;
  assign w_csr  = {3'b000, r_valid, r_lostie, r_lostf, locked, r_en};

  always_comb begin
    bus_out = '0;
    if (rd && !rst) begin
      if (w_sel_csr)      bus_out = w_csr;
      else if (w_sel_exp) bus_out = r_monexp;
      else if (w_sel_cnt) bus_out = r_moncnt;
    end
  end

endmodule

// File: tb/tb_atmega_pll_lock_mon.sv
// Directed bench for atmega_pll_lock_mon: lock acquire/loss, wrong target, saturation,
// disable mid-window, LOSTF set-vs-clear race and async reset.
`timescale 1ns/1ps
module tb_atmega_pll_lock_mon;

  localparam logic [15:0] A_CSR = 16'h0033;
  localparam logic [15:0] A_EXP = 16'h0034;
  localparam logic [15:0] A_CNT = 16'h0035;

  logic        clk = 1'b0, rst = 1'b0, mon_ck = 1'b0, mon_ck2 = 1'b0;
  logic [15:0] addr = '0, addr2 = '0;
  logic        wr = 1'b0, rd = 1'b0, wr2 = 1'b0, rd2 = 1'b0;
  logic [7:0]  bus_in = '0, bus_in2 = '0;
  logic [7:0]  bus_out, bus_out2;
  logic        locked, irq, locked2, irq2;

  realtime mon_half = 5.208;
  bit      mon_run  = 1'b1;
  int      cyc      = 0;
  int      e0;
  int      n_vec    = 0;
  int      n_err    = 0;

  atmega_pll_lock_mon dut (
    .rst(rst), .clk(clk), .mon_ck(mon_ck), .addr(addr), .wr(wr), .rd(rd),
    .bus_in(bus_in), .bus_out(bus_out), .locked(locked), .irq(irq)
  );

  atmega_pll_lock_mon #(.WINDOW(1024)) dut_w (
    .rst(rst), .clk(clk), .mon_ck(mon_ck2), .addr(addr2), .wr(wr2), .rd(rd2),
    .bus_in(bus_in2), .bus_out(bus_out2), .locked(locked2), .irq(irq2)
  );

  always #31.25 clk = ~clk;
  always begin
    #(mon_half);
    if (mon_run) mon_ck = ~mon_ck;
  end
  always #5.208 mon_ck2 = ~mon_ck2;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; bus_in = d; wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; rd = 1'b1;
    #2;
    d = bus_out;
    rd = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #5 rst = 1'b1;
    #100 rst = 1'b0;
    wait_cyc(cyc + 2);
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_csr got=%h exp=00", d); end
    bus_read(A_EXP, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_exp got=%h exp=00", d); end
    bus_read(A_CNT, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_cnt got=%h exp=00", d); end
    n_vec++; if (locked !== 1'b0 || irq !== 1'b0) begin
      n_err++; $display("FAIL reset_outs locked=%b irq=%b exp=0,0", locked, irq);
    end
    addr = A_CSR; rd = 1'b0; #1;
    n_vec++; if (bus_out !== 8'h00) begin n_err++; $display("FAIL no_rd_bus got=%h exp=00", bus_out); end
  endtask

  task automatic test_lock_acquire();
    logic [7:0] d;
    bus_write(A_EXP, 8'd96);
    bus_write(A_CSR, 8'h01);
    e0 = cyc;
    wait_cyc(e0 + 255);
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h01) begin n_err++; $display("FAIL valid_early csr=%h exp=01", d); end
    wait_cyc(e0 + 256);
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h11) begin n_err++; $display("FAIL valid_set csr=%h exp=11", d); end
    bus_read(A_CNT, d);
    n_vec++; if (d < 8'd95 || d > 8'd97) begin n_err++; $display("FAIL cnt_96 got=%0d exp=95..97", d); end
    wait_cyc(e0 + 767);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_early locked=%b exp=0", locked); end
    wait_cyc(e0 + 768);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_edge locked=%b exp=1", locked); end
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h13) begin n_err++; $display("FAIL lock_csr csr=%h exp=13", d); end
  endtask

  task automatic test_lock_loss();
    logic [7:0] d;
    mon_run = 1'b0;
    wait_cyc(e0 + 799);
    bus_write(A_CSR, 8'h09);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle irq=%b exp=0", irq); end
    wait_cyc(e0 + 1023);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL loss_early locked=%b exp=1", locked); end
    wait_cyc(e0 + 1024);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL loss_edge locked=%b exp=0", locked); end
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h1D) begin n_err++; $display("FAIL loss_csr csr=%h exp=1d", d); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL loss_irq irq=%b exp=1", irq); end
    bus_read(A_CNT, d);
    n_vec++; if (d > 8'd6) begin n_err++; $display("FAIL dead_cnt got=%0d exp<=6", d); end
    bus_write(A_CSR, 8'h05);
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h11) begin n_err++; $display("FAIL w1c_csr csr=%h exp=11", d); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq irq=%b exp=0", irq); end
  endtask

  task automatic test_wrong_target();
    logic [7:0] d;
    bus_write(A_CSR, 8'h00);
    mon_half = 5.208;
    mon_run  = 1'b1;
    bus_write(A_EXP, 8'd48);
    wait_cyc(cyc + 10);
    bus_write(A_CSR, 8'h01);
    e0 = cyc;
    for (int w = 1; w <= 4; w++) begin
      wait_cyc(e0 + 256 * w);
      bus_read(A_CNT, d);
      n_vec++; if (locked !== 1'b0 || d < 8'd95 || d > 8'd97) begin
        n_err++; $display("FAIL wrong_tgt w=%0d locked=%b cnt=%0d exp=0,95..97", w, locked, d);
      end
    end
    mon_half = 10.417;
    wait_cyc(e0 + 1536);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL relock_w2 locked=%b exp=0", locked); end
    wait_cyc(e0 + 1791);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL relock_early locked=%b exp=0", locked); end
    wait_cyc(e0 + 1792);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL relock_edge locked=%b exp=1", locked); end
    bus_read(A_CNT, d);
    n_vec++; if (d < 8'd46 || d > 8'd50) begin n_err++; $display("FAIL cnt_48 got=%0d exp=46..50", d); end
  endtask

  task automatic test_saturation();
    int e2;
    logic [7:0] d;
    @(negedge clk); addr2 = A_EXP; bus_in2 = 8'd255; wr2 = 1'b1;
    @(posedge clk); #1; wr2 = 1'b0;
    @(negedge clk); addr2 = A_CSR; bus_in2 = 8'h01; wr2 = 1'b1;
    @(posedge clk); #1; wr2 = 1'b0;
    e2 = cyc;
    wait_cyc(e2 + 1024);
    addr2 = A_CNT; rd2 = 1'b1; #2; d = bus_out2; rd2 = 1'b0;
    n_vec++; if (d !== 8'd255) begin n_err++; $display("FAIL sat_cnt got=%0d exp=255", d); end
    wait_cyc(e2 + 3071);
    n_vec++; if (locked2 !== 1'b0) begin n_err++; $display("FAIL sat_early locked=%b exp=0", locked2); end
    wait_cyc(e2 + 3072);
    n_vec++; if (locked2 !== 1'b1) begin n_err++; $display("FAIL sat_lock locked=%b exp=1", locked2); end
  endtask

  task automatic test_disable_mid();
    int wend;
    logic [7:0] d, cnt_before;
    wend = e0 + 256 * ((cyc - e0) / 256 + 1);
    wait_cyc(wend + 50);
    bus_read(A_CNT, cnt_before);
    wait_cyc(wend + 99);
    bus_write(A_CSR, 8'h00);
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h00 || locked !== 1'b0) begin
      n_err++; $display("FAIL disable csr=%h locked=%b exp=00,0", d, locked);
    end
    bus_read(A_CNT, d);
    n_vec++; if (d !== cnt_before) begin n_err++; $display("FAIL disable_cnt got=%0d exp=%0d", d, cnt_before); end
    wait_cyc(cyc + 20);
    bus_write(A_CSR, 8'h01);
    e0 = cyc;
    wait_cyc(e0 + 767);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reacq_early locked=%b exp=0", locked); end
    wait_cyc(e0 + 768);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL reacq_edge locked=%b exp=1", locked); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    wait_cyc(e0 + 799);
    bus_write(A_EXP, 8'd10);
    wait_cyc(e0 + 1023);
    bus_write(A_CSR, 8'h05);
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h15) begin n_err++; $display("FAIL set_wins csr=%h exp=15", d); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL set_wins_lock locked=%b exp=0", locked); end
    #10 rst = 1'b1;
    #5;
    addr = A_EXP; rd = 1'b1; #1;
    n_vec++; if (bus_out !== 8'h00) begin n_err++; $display("FAIL rst_bus got=%h exp=00", bus_out); end
    rd = 1'b0;
    n_vec++; if (locked !== 1'b0 || irq !== 1'b0) begin
      n_err++; $display("FAIL rst_outs locked=%b irq=%b exp=0,0", locked, irq);
    end
    #5 rst = 1'b0;
    bus_read(A_CSR, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_csr got=%h exp=00", d); end
    bus_read(A_EXP, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_exp got=%h exp=00", d); end
    bus_read(A_CNT, d);
    n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_cnt got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_wrong_target();
    test_saturation();
    test_disable_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
